// File: rtl/command_decoder_pkg.sv
// Shared SUMP command definitions: opcodes, receive-state enum and the
// decoded strobe bundle.
package command_decoder_pkg;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_XON       = 8'h11;
    localparam logic [7:0] OP_XOFF      = 8'h13;
    localparam logic [7:0] OP_DIV       = 8'h80;
    localparam logic [7:0] OP_SIZE      = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;
    localparam logic [7:0] OP_TRIG_BASE = 8'hC0;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

    typedef struct packed {
        logic       soft_reset;
        logic       arm;
        logic       send_id;
        logic       xon;
        logic       xoff;
        logic       wr_divider;
        logic       wr_size;
        logic       wr_flags;
        logic [3:0] wr_trig_mask;
        logic [3:0] wr_trig_value;
        logic [3:0] wr_trig_config;
    } strobe_t;

endpackage

// File: rtl/command_timeout.sv
// Inter-byte idle counter; expired flags the clock on which the
// TIMEOUT_CYCLES-th consecutive idle clock is reached.
module command_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = enable && !clear && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/command_decoder.sv
// Assembles the SUMP byte stream into short/long commands and emits
// registered opcode, argument and one-cycle decoded strobes.
module command_decoder
    import command_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        cmdValid,
    output logic        softReset,
    output logic        arm,
    output logic        sendId,
    output logic        xon,
    output logic        xoff,
    output logic        wrDivider,
    output logic        wrSize,
    output logic        wrFlags,
    output logic [3:0]  wrTrigMask,
    output logic [3:0]  wrTrigValue,
    output logic [3:0]  wrTrigConfig,
    output logic        busy
);

    state_t      state;
    logic [7:0]  pending;
    logic [1:0]  arg_count;
    logic [23:0] arg_shift;
    logic        expired;
    logic        in_arg;
    logic        done_short;
    logic        done_long;
    logic [7:0]  done_op;
    strobe_t     strobe_d;
    strobe_t     strobe_q;

    assign in_arg     = (state == ARG);
    assign done_short = !in_arg && rxValid && !rxByte[7];
    assign done_long  = in_arg && rxValid && (arg_count == 2'd3);
    assign done_op    = in_arg ? pending : rxByte;

    command_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_arg || rxValid),
        .enable (in_arg),
        .expired(expired)
    );

    always_comb begin
        strobe_d = '0;
        if (done_short || done_long) begin
            case (done_op)
                OP_RESET: strobe_d.soft_reset = 1'b1;
                OP_ARM:   strobe_d.arm        = 1'b1;
                OP_ID:    strobe_d.send_id    = 1'b1;
                OP_XON:   strobe_d.xon        = 1'b1;
                OP_XOFF:  strobe_d.xoff       = 1'b1;
                OP_DIV:   strobe_d.wr_divider = 1'b1;
                OP_SIZE:  strobe_d.wr_size    = 1'b1;
                OP_FLAGS: strobe_d.wr_flags   = 1'b1;
                default: begin
                    // 0xC0..0xCF: bits [3:2] select the stage, [1:0] the register
                    if (done_op[7:4] == OP_TRIG_BASE[7:4]) begin
                        case (done_op[1:0])
                            2'd0: strobe_d.wr_trig_mask[done_op[3:2]]   = 1'b1;
                            2'd1: strobe_d.wr_trig_value[done_op[3:2]]  = 1'b1;
                            2'd2: strobe_d.wr_trig_config[done_op[3:2]] = 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            arg_count <= '0;
            arg_shift <= '0;
            opcode    <= '0;
            data      <= '0;
            cmdValid  <= 1'b0;
            busy      <= 1'b0;
            strobe_q  <= '0;
        end else begin
            strobe_q <= strobe_d;
            cmdValid <= done_short || done_long;
            case (state)
                IDLE: begin
                    if (rxValid) begin
                        if (!rxByte[7]) begin
                            opcode <= rxByte;
                        end else begin
                            pending   <= rxByte;
                            arg_shift <= '0;
                            arg_count <= '0;
                            busy      <= 1'b1;
                            state     <= ARG;
                        end
                    end
                end
                ARG: begin
                    if (rxValid) begin
                        arg_shift <= {rxByte, arg_shift[23:8]};
                        arg_count <= arg_count + 2'd1;
                        if (arg_count == 2'd3) begin
                            opcode <= pending;
                            data   <= {rxByte, arg_shift};
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (expired) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign softReset    = strobe_q.soft_reset;
    assign arm          = strobe_q.arm;
    assign sendId       = strobe_q.send_id;
    assign xon          = strobe_q.xon;
    assign xoff         = strobe_q.xoff;
    assign wrDivider    = strobe_q.wr_divider;
    assign wrSize       = strobe_q.wr_size;
    assign wrFlags      = strobe_q.wr_flags;
    assign wrTrigMask   = strobe_q.wr_trig_mask;
    assign wrTrigValue  = strobe_q.wr_trig_value;
    assign wrTrigConfig = strobe_q.wr_trig_config;

endmodule

// File: doc/command_decoder.md
# command_decoder

Receives the SUMP command byte stream from the UART receiver and assembles it into complete commands. Short commands are one opcode byte. Long commands are an opcode byte plus four argument bytes, LSB first. For each completed command it outputs a registered opcode, a 32-bit argument and single-cycle write/action strobes. These drive the flags register (data[7:0] plus its write strobe), divider, sample-count and trigger-stage registers, and the core control logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle clocks allowed between argument bytes before a partial long command is discarded; minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rxByte  in  8  received byte; valid only while rxValid=1.
- rxValid  in  1  one-cycle pulse per received byte.
- opcode  out  8  opcode of last completed command.
- data  out  32  argument of last completed long command; byte1 → data[7:0], byte4 → data[31:24].
- cmdValid  out  1  one-cycle pulse per completed command, known or unknown.
- softReset, arm, sendId, xon, xoff  out  1 each  one-cycle pulses for short opcodes 0x00, 0x01, 0x02, 0x11, 0x13.
- wrDivider, wrSize, wrFlags  out  1 each  one-cycle pulses for long opcodes 0x80, 0x81, 0x82.
- wrTrigMask, wrTrigValue, wrTrigConfig  out  4 each  one-hot pulses for opcodes 0xC0+4n, 0xC1+4n, 0xC2+4n; n = stage 0..3.
- busy  out  1  high while a long command is partially received.

## Operation
- States:
  - IDLE: waiting for an opcode byte.
  - ARG: collecting argument bytes; a 2-bit argument counter tracks 0..3.
- IDLE, byte received:
  - rxByte[7]=0: complete a short command immediately.
  - rxByte[7]=1: latch rxByte as the pending opcode, clear the argument shift register, go to ARG with counter=0.
- ARG, byte received:
  - Store the byte at position counter, then increment the counter.
  - On the 4th argument byte: complete the long command and return to IDLE.
- Complete command:
  - Update opcode.
  - Update data for long commands only; a short command leaves data unchanged.
  - Pulse cmdValid and the matching decoded strobe.
- Unknown opcodes:
  - cmdValid pulses; no decoded strobe fires.
  - An unknown long opcode (including 0xC3+4n) still consumes 4 argument bytes.
- Timeout:
  - In ARG, an inter-byte counter increments each clock without rxValid and clears on rxValid.
  - On reaching TIMEOUT_CYCLES: return to IDLE, discard the partial command, emit no pulses.
- Resync: the host's five consecutive 0x00 bytes, received from IDLE, produce five softReset pulses. A 0x00 received in ARG is an argument byte, not a command.
- Outputs opcode and data hold stable from cmdValid until the next completed command.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-command discards the partial command immediately (asynchronously).
- Latency:
  - cmdValid and strobes go high exactly 1 clock after the rxValid cycle of the final byte.
  - opcode and data are valid in that same cycle.
- At most one strobe group is active per cycle. Strobes are never asserted for more than 1 clock.
- Back-to-back rxValid on consecutive clocks is fully supported; no byte is dropped.
- rxValid in the same cycle the timeout count is reached: the byte is accepted and the timeout is ignored.
- busy goes high the clock after a long opcode is accepted. It goes low the clock after the final byte or on timeout.

## Structure
- Shared package holds:
  - Opcode constants: OP_RESET=0x00, OP_ARM=0x01, OP_ID=0x02, OP_XON=0x11, OP_XOFF=0x13, OP_DIV=0x80, OP_SIZE=0x81, OP_FLAGS=0x82, OP_TRIG_BASE=0xC0.
  - The state enum, reused by the UART transmitter and the ID responder.
- One sub-module: command_timeout, the inter-byte counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.
- Opcode-to-strobe decode is inline combinational logic feeding one output register stage.

## Test plan
- Single 0x01 byte → 1 clock later opcode=0x01, arm=1 and cmdValid=1 for one clock; data unchanged.
- Bytes 0x82,0xC3,0x00,0x00,0x00 back-to-back → opcode=0x82, data=0x000000C3, wrFlags pulse once; busy high for 4 clocks.
- Bytes 0xC5,0x78,0x56,0x34,0x12 → data=0x12345678, wrTrigValue=4'b0010, no other strobe.
- With TIMEOUT_CYCLES=16: send 0x80,0xAA, then idle 16 clocks, then 0x02 → no wrDivider, busy drops, then sendId pulses with opcode=0x02.
- Five 0x00 bytes from IDLE → five softReset pulses, each 1 clock; a 0x00 sent mid-argument → no softReset.
- reset asserted after 0x81,0x11 → all outputs 0. A following 0x11 → xon pulse, not an argument byte.
